// File: rtl/archie_mem_arbiter.sv
// rtl/archie_mem_arbiter.sv - SDRAM Wishbone arbiter: buffered HPS loader writes over N core masters
module archie_mem_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 32,
  parameter int LDR_DEPTH   = 4,
  parameter int RR_MODE     = 1,
  localparam int SEL_W      = DATA_W / 8
) (
  input  logic                          clk_sys,
  input  logic                          reset,

  input  logic                          loader_active,
  input  logic                          loader_we,
  input  logic [ADDR_W-1:0]             loader_addr,
  input  logic [DATA_W-1:0]             loader_data,
  input  logic [SEL_W-1:0]              loader_sel,
  output logic                          loader_wait,
  output logic                          ldr_overflow,

  input  logic [NUM_MASTERS-1:0]        m_cyc,
  input  logic [NUM_MASTERS-1:0]        m_stb,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_adr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_dat,
  input  logic [NUM_MASTERS*SEL_W-1:0]  m_sel,
  input  logic [NUM_MASTERS*3-1:0]      m_cti,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [DATA_W-1:0]             m_dat_i,

  output logic                          s_cyc,
  output logic                          s_stb,
  output logic                          s_we,
  output logic [ADDR_W-1:0]             s_adr,
  output logic [DATA_W-1:0]             s_dat,
  output logic [SEL_W-1:0]              s_sel,
  output logic [2:0]                    s_cti,
  input  logic                          s_ack,
  input  logic [DATA_W-1:0]             s_dat_i
);

  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int PW = (LDR_DEPTH > 1) ? $clog2(LDR_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOADER = 2'd1,
    S_MASTER = 2'd2
  } state_t;

  state_t            state;
  logic [GW-1:0]     grant;
  logic [GW-1:0]     rr_ptr;
  logic [GW-1:0]     grant_next;

  // Loader write FIFO: storage, pointers and occupancy
  logic [ADDR_W-1:0] fifo_adr [LDR_DEPTH];
  logic [DATA_W-1:0] fifo_dat [LDR_DEPTH];
  logic [SEL_W-1:0]  fifo_sel [LDR_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     fifo_count_next;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  // Granted master's request, extracted from the packed buses
  logic [ADDR_W-1:0] g_adr;
  logic [DATA_W-1:0] g_dat;
  logic [SEL_W-1:0]  g_sel;
  logic [2:0]        g_cti;

  assign fifo_full  = (fifo_count == CW'(LDR_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign push       = loader_we && !fifo_full;
  assign pop        = (state == S_LOADER) && s_ack;

  assign g_adr = m_adr[int'(grant)*ADDR_W +: ADDR_W];
  assign g_dat = m_dat[int'(grant)*DATA_W +: DATA_W];
  assign g_sel = m_sel[int'(grant)*SEL_W +: SEL_W];
  assign g_cti = m_cti[int'(grant)*3 +: 3];

  assign m_dat_i = s_dat_i;

  // Occupancy after this cycle's push/pop; a simultaneous pair cancels out
  always_comb begin
    fifo_count_next = fifo_count;
    if (push && !pop) begin
      fifo_count_next = fifo_count + CW'(1);
    end else if (!push && pop) begin
      fifo_count_next = fifo_count - CW'(1);
    end
  end

  // FIFO payload storage; contents are don't-care while the slot is empty
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_adr[wr_ptr] <= loader_addr;
      fifo_dat[wr_ptr] <= loader_data;
      fifo_sel[wr_ptr] <= loader_sel;
    end
  end

  // FIFO pointers, occupancy, backpressure and sticky overflow flag
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      loader_wait  <= 1'b0;
      ldr_overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      fifo_count  <= fifo_count_next;
      loader_wait <= (fifo_count_next >= CW'(LDR_DEPTH - 1));
      if (loader_we && fifo_full) begin
        ldr_overflow <= 1'b1;
      end
    end
  end

  // Next grant: rotate from the last winner in round-robin mode, else lowest index
  always_comb begin
    logic found;
    int   idx;
    grant_next = grant;
    found      = 1'b0;
    idx        = 0;
    if (RR_MODE != 0) begin
      for (int k = 1; k <= NUM_MASTERS; k++) begin
        idx = (int'(rr_ptr) + k) % NUM_MASTERS;
        if (!found && (((m_cyc >> idx) & NUM_MASTERS'(1)) != '0)) begin
          found      = 1'b1;
          grant_next = GW'(idx);
        end
      end
    end else begin
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
        if (((m_cyc >> k) & NUM_MASTERS'(1)) != '0) begin
          grant_next = GW'(k);
        end
      end
    end
  end

  // Arbitration FSM: loader beats first, then masters; every tenure ends in IDLE
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      grant  <= '0;
      rr_ptr <= GW'(NUM_MASTERS - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            state <= S_LOADER;
          end else if (!loader_active && (m_cyc != '0)) begin
            state  <= S_MASTER;
            grant  <= grant_next;
            rr_ptr <= grant_next;
          end
        end
        S_LOADER: begin
          if (s_ack) begin
            state <= S_IDLE;
          end
        end
        S_MASTER: begin
          // Tenure lasts as long as the master keeps CYC up, bursts included
          if (!m_cyc[grant]) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Slave request mux and per-master acknowledge steering
  always_comb begin
    s_cyc = 1'b0;
    s_stb = 1'b0;
    s_we  = 1'b0;
    s_adr = '0;
    s_dat = '0;
    s_sel = '0;
    s_cti = 3'b000;
    m_ack = '0;
    case (state)
      S_LOADER: begin
        s_cyc = 1'b1;
        s_stb = 1'b1;
        s_we  = 1'b1;
        s_adr = fifo_adr[rd_ptr] & ~ADDR_W'(3);
        s_dat = fifo_dat[rd_ptr];
        s_sel = fifo_sel[rd_ptr];
        s_cti = 3'b000;
      end
      S_MASTER: begin
        s_cyc        = m_cyc[grant];
        s_stb        = m_stb[grant];
        s_we         = m_we[grant];
        s_adr        = g_adr & ~ADDR_W'(3);
        s_dat        = g_dat;
        s_sel        = g_sel;
        s_cti        = g_cti;
        m_ack[grant] = s_ack;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_archie_mem_arbiter.sv
// tb/tb_archie_mem_arbiter.sv - directed scoreboard bench for archie_mem_arbiter
module tb_archie_mem_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        loader_active;
  logic        loader_we;
  logic [23:0] loader_addr;
  logic [31:0] loader_data;
  logic [3:0]  loader_sel;
  logic        loader_wait;
  logic        ldr_overflow;
  logic [1:0]  m_cyc;
  logic [1:0]  m_stb;
  logic [1:0]  m_we;
  logic [47:0] m_adr;
  logic [63:0] m_dat;
  logic [7:0]  m_sel;
  logic [5:0]  m_cti;
  logic [1:0]  m_ack;
  logic [31:0] m_dat_i;
  logic        s_cyc;
  logic        s_stb;
  logic        s_we;
  logic [23:0] s_adr;
  logic [31:0] s_dat;
  logic [3:0]  s_sel;
  logic [2:0]  s_cti;
  logic        s_ack;
  logic [31:0] s_dat_i;

  archie_mem_arbiter dut (
    .clk_sys(clk_sys), .reset(reset),
    .loader_active(loader_active), .loader_we(loader_we),
    .loader_addr(loader_addr), .loader_data(loader_data), .loader_sel(loader_sel),
    .loader_wait(loader_wait), .ldr_overflow(ldr_overflow),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat(m_dat),
    .m_sel(m_sel), .m_cti(m_cti), .m_ack(m_ack), .m_dat_i(m_dat_i),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat(s_dat),
    .s_sel(s_sel), .s_cti(s_cti), .s_ack(s_ack), .s_dat_i(s_dat_i)
  );

  always #5 clk_sys = ~clk_sys;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [59:0] ldr_q[$];
  int          grant_q[$];
  logic [59:0] exp_w;
  int          exp_g;
  int          model_count = 0;
  logic        model_ovf = 1'b0;
  int          writes_issued = 0;
  logic [1:0]  ack_prev = 2'b00;
  int          slave_lat = 0;
  logic        stall = 1'b0;
  int          wcnt = 0;
  logic        no_ack_mode = 1'b0;
  int          base;
  int          beats;
  int          first_i;
  int          last_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present one loader beat for the current cycle and record the model's view of it
  task automatic drive_beat(input logic [23:0] a, input logic [31:0] d, input logic [3:0] s);
    loader_we   = 1'b1;
    loader_addr = a;
    loader_data = d;
    loader_sel  = s;
    if (model_count < 4) begin
      model_count++;
      ldr_q.push_back({a & ~24'h3, d, s});
    end else begin
      model_ovf = 1'b1;
    end
  endtask

  // Finish the current cycle: slave response, scoreboard pop on ack, post-edge flag checks
  task automatic cycle_end();
    #1;
    if (s_cyc && s_stb && !stall) begin
      if (wcnt == slave_lat) begin
        s_ack = 1'b1;
        wcnt  = 0;
      end else begin
        s_ack = 1'b0;
        wcnt++;
      end
    end else begin
      s_ack = 1'b0;
      wcnt  = 0;
    end
    s_dat_i = $urandom;
    @(negedge clk_sys);
    ack_prev = m_ack;
    if (no_ack_mode) chk("m_ack_quiet_loader_active", m_ack, 2'b00);
    if (s_ack && s_cyc && s_stb) begin
      chk("m_dat_i", m_dat_i, s_dat_i);
      if (s_we) begin
        writes_issued++;
        chk("ldr_write_expected", ldr_q.size() != 0, 1);
        if (ldr_q.size() != 0) begin
          exp_w = ldr_q.pop_front();
          chk("ldr_write_beat", {s_adr, s_dat, s_sel}, exp_w);
          chk("ldr_write_cti", s_cti, 3'b000);
          chk("ldr_write_no_m_ack", m_ack, 2'b00);
        end
        model_count--;
      end else begin
        chk("read_ack_expected", grant_q.size() != 0, 1);
        if (grant_q.size() != 0) begin
          exp_g = grant_q.pop_front();
          chk("grant_m_ack", m_ack, 2'b01 << exp_g);
          chk("grant_route_adr", s_adr, m_adr[exp_g*24 +: 24] & ~24'h3);
        end
      end
    end
    @(posedge clk_sys);
    #1;
    chk("loader_wait", loader_wait, model_count >= 3);
    chk("ldr_overflow", ldr_overflow, model_ovf);
  endtask

  initial begin
    reset = 1'b1; loader_active = 1'b0; loader_we = 1'b0;
    loader_addr = '0; loader_data = '0; loader_sel = '0;
    m_cyc = '0; m_stb = '0; m_we = '0; m_cti = '0;
    m_adr = {24'h000107, 24'h000203};
    m_dat = {32'h11112222, 32'h33334444}; m_sel = 8'hFF;
    s_ack = 1'b0; s_dat_i = '0;
    @(posedge clk_sys); @(posedge clk_sys); #1;
    chk("rst_s_cyc", s_cyc, 0); chk("rst_s_stb", s_stb, 0); chk("rst_s_we", s_we, 0);
    chk("rst_m_ack", m_ack, 0); chk("rst_loader_wait", loader_wait, 0);
    chk("rst_ldr_overflow", ldr_overflow, 0);
    chk("rst_s_bus", {s_adr, s_dat, s_sel, s_cti}, 0);
    reset = 1'b0;

    // Single loader write, slave acks on the third request cycle
    loader_active = 1'b1; slave_lat = 2;
    drive_beat(24'h000003, 32'hDEADBEEF, 4'hF);
    cycle_end();
    loader_we = 1'b0;
    for (int i = 0; i < 20 && writes_issued < 1; i++) cycle_end();
    for (int i = 0; i < 4; i++) cycle_end();
    chk("single_write_count", writes_issued, 1);
    chk("single_write_q_empty", ldr_q.size(), 0);
    chk("single_write_s_cyc_idle", s_cyc, 0);

    // Six back-to-back beats into a stalled slave: two are dropped
    stall = 1'b1; slave_lat = 0; base = writes_issued;
    for (int i = 0; i < 6; i++) begin
      drive_beat(24'h000100 + 24'(i * 4) + 24'(i), 32'hA5A50000 + 32'(i), 4'(i + 1));
      cycle_end();
      if (i == 1) chk("wait_low_after_2nd", loader_wait, 0);
      if (i == 2) chk("wait_high_after_3rd", loader_wait, 1);
    end
    loader_we = 1'b0;
    chk("overflow_set", ldr_overflow, 1);
    stall = 1'b0;
    for (int i = 0; i < 40 && (writes_issued - base) < 4; i++) cycle_end();
    for (int i = 0; i < 6; i++) cycle_end();
    chk("drain_count", writes_issued - base, 4);
    chk("drain_q_empty", ldr_q.size(), 0);
    chk("overflow_sticky", ldr_overflow, 1);

    // Two masters issuing single reads back to back: round-robin alternation
    loader_active = 1'b0;
    grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(0); grant_q.push_back(1);
    for (int i = 0; i < 60 && grant_q.size() > 0; i++) begin
      for (int k = 0; k < 2; k++) begin
        m_cyc[k] = !ack_prev[k];
        m_stb[k] = !ack_prev[k];
      end
      cycle_end();
    end
    m_cyc = '0; m_stb = '0;
    cycle_end(); cycle_end();
    chk("rr_all_grants_seen", grant_q.size(), 0);

    // Master 0 burst survives loader_active rising; loader then drains; masters held off
    for (int k = 0; k < 4; k++) grant_q.push_back(0);
    m_cyc = 2'b11; m_stb = 2'b11; beats = 0; first_i = -1; last_i = -1;
    base = writes_issued;
    for (int i = 0; i < 30 && beats < 4; i++) begin
      m_cti[2:0] = (beats == 3) ? 3'b111 : 3'b010;
      cycle_end();
      loader_we = 1'b0;
      if (ack_prev[0]) begin
        beats++;
        if (first_i < 0) first_i = i;
        last_i = i;
      end
      if (beats == 1 && !loader_active) begin
        loader_active = 1'b1;
        drive_beat(24'h00ABC1, 32'hCAFEF00D, 4'h3);
      end
    end
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_cti = '0;
    chk("burst_beats", beats, 4);
    chk("burst_contiguous", last_i - first_i, 3);
    no_ack_mode = 1'b1;
    for (int i = 0; i < 8; i++) cycle_end();
    no_ack_mode = 1'b0;
    chk("loader_after_burst", writes_issued - base, 1);
    chk("loader_after_burst_q", ldr_q.size(), 0);
    loader_active = 1'b0;
    grant_q.push_back(1);
    for (int i = 0; i < 20 && grant_q.size() > 0; i++) begin
      m_cyc[1] = !ack_prev[1];
      m_stb[1] = !ack_prev[1];
      cycle_end();
    end
    m_cyc = '0; m_stb = '0;
    cycle_end();
    chk("master1_after_loader", grant_q.size(), 0);

    // Reset in the middle of a stalled loader write with two beats queued
    loader_active = 1'b1; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_beat(24'h000200 + 24'(i * 4), 32'h5A5A0000 + 32'(i), 4'hF);
      cycle_end();
    end
    loader_we = 1'b0;
    cycle_end();
    chk("pre_reset_s_cyc", s_cyc, 1);
    reset = 1'b1;
    #1;
    chk("reset_s_cyc_immediate", s_cyc, 0);
    chk("reset_s_stb_immediate", s_stb, 0);
    ldr_q.delete(); model_count = 0; model_ovf = 1'b0;
    cycle_end();
    reset = 1'b0; stall = 1'b0; base = writes_issued;
    for (int i = 0; i < 10; i++) cycle_end();
    chk("no_write_after_reset", writes_issued - base, 0);
    chk("idle_after_reset", s_cyc, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
